// File: rtl/switch_pkg.sv
// Shared types and constants for the switch bounce generator.
package switch_pkg;

    localparam int LFSR_W = 16;

    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } sw_state_e;

endpackage

// File: rtl/switch_bounce_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, advances every non-reset cycle.
module lfsr16
    import switch_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] o_lfsr
);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_fb;

    // An all-zero seed would lock the register at zero forever.
    if (SEED == '0) begin : g_seed_check
        $error("lfsr16: SEED must be nonzero");
    end

    assign w_fb = ^(r_lfsr & LFSR_TAPS);

    // Shift register with XOR feedback; reloads the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/switch_bounce_gen.sv
// Emulates a bouncing mechanical switch for on-board debouncer testing.
//
// state  | meaning
// IDLE   | ready for a request, pin stable at last settled level
// BOUNCE | pin toggling with pseudo-random segment lengths
// SETTLE | pin held at target for 2^N_SETTLE cycles
module switch_bounce_gen
    import switch_pkg::*;
#(
    parameter int unsigned       N_INTERVAL = 4,
    parameter int unsigned       N_SETTLE   = 6,
    parameter bit                IS_PULLUP  = 1'b0,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_state,
    input  logic [3:0] i_req_nbounce,
    output logic       o_sig_bouncy,
    output logic       o_state,
    output logic       o_done
);

    localparam int SEG_W = N_INTERVAL + 1;
    localparam int SET_W = N_SETTLE + 1;
    localparam logic [SET_W-1:0] SETTLE_LEN = {1'b1, {N_SETTLE{1'b0}}};

    sw_state_e         r_state, w_state_nxt;
    logic              r_level, w_level_nxt;
    logic              r_target, w_target_nxt;
    logic              r_ostate, w_ostate_nxt;
    logic              r_done, w_done_nxt;
    logic [SEG_W-1:0]  r_seg_cnt, w_seg_nxt;
    logic [4:0]        r_tog_cnt, w_tog_nxt;
    logic [SET_W-1:0]  r_set_cnt, w_set_nxt;

    logic [LFSR_W-1:0] w_lfsr;
    logic [SEG_W-1:0]  w_seg_len;
    logic              w_unused_lfsr;

    lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .o_lfsr (w_lfsr)
    );

    // Segment length drawn fresh whenever a segment starts: 1..2^N_INTERVAL.
    assign w_seg_len     = {1'b0, w_lfsr[N_INTERVAL-1:0]} + SEG_W'(1);
    assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:N_INTERVAL];

    // Next-state and datapath decisions; every target defaults to hold.
    always_comb begin
        w_state_nxt  = r_state;
        w_level_nxt  = r_level;
        w_target_nxt = r_target;
        w_ostate_nxt = r_ostate;
        w_done_nxt   = 1'b0;
        w_seg_nxt    = r_seg_cnt;
        w_tog_nxt    = r_tog_cnt;
        w_set_nxt    = r_set_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_target_nxt = i_req_state;
                    if (i_req_state != r_ostate) begin
                        w_state_nxt = ST_BOUNCE;
                        w_level_nxt = i_req_state;
                        w_seg_nxt   = w_seg_len;
                        w_tog_nxt   = {i_req_nbounce, 1'b0};
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_set_nxt   = SETTLE_LEN;
                    end
                end
            end
            ST_BOUNCE: begin
                if (r_seg_cnt <= SEG_W'(1)) begin
                    if (r_tog_cnt != 5'd0) begin
                        w_level_nxt = ~r_level;
                        w_tog_nxt   = r_tog_cnt - 5'd1;
                        w_seg_nxt   = w_seg_len;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_set_nxt   = SETTLE_LEN;
                    end
                end else begin
                    w_seg_nxt = r_seg_cnt - SEG_W'(1);
                end
            end
            ST_SETTLE: begin
                if (r_set_cnt <= SET_W'(1)) begin
                    w_state_nxt  = ST_IDLE;
                    w_ostate_nxt = r_target;
                    w_done_nxt   = 1'b1;
                end else begin
                    w_set_nxt = r_set_cnt - SET_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_level   <= 1'b0;
            r_target  <= 1'b0;
            r_ostate  <= 1'b0;
            r_done    <= 1'b0;
            r_seg_cnt <= '0;
            r_tog_cnt <= '0;
            r_set_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_level   <= w_level_nxt;
            r_target  <= w_target_nxt;
            r_ostate  <= w_ostate_nxt;
            r_done    <= w_done_nxt;
            r_seg_cnt <= w_seg_nxt;
            r_tog_cnt <= w_tog_nxt;
            r_set_cnt <= w_set_nxt;
        end
    end

    assign o_req_ready  = (r_state == ST_IDLE);
    assign o_sig_bouncy = r_level ^ IS_PULLUP;
    assign o_state      = r_ostate;
    assign o_done       = r_done;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Bench for switch_bounce_gen: trace model plus directed scenarios.
module tb_switch_bounce_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst0 = 1'b1, rst1 = 1'b1;
    logic i_req_valid = 1'b0, i_req_state = 1'b0;
    logic [3:0] i_req_nbounce = 4'd0;
    logic o_req_ready, o_sig_bouncy, o_state, o_done;
    logic valid1 = 1'b0, state1 = 1'b0;
    logic [3:0] nb1 = 4'd0;
    logic ready1, pin1, ostate1, done1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    switch_bounce_gen #(.N_INTERVAL(4), .N_SETTLE(6), .IS_PULLUP(1'b0), .LFSR_SEED(SEED)) dut0 (
        .clk(clk), .rst(rst0), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_state(i_req_state), .i_req_nbounce(i_req_nbounce),
        .o_sig_bouncy(o_sig_bouncy), .o_state(o_state), .o_done(o_done));

    switch_bounce_gen #(.N_INTERVAL(4), .N_SETTLE(6), .IS_PULLUP(1'b1), .LFSR_SEED(SEED)) dut1 (
        .clk(clk), .rst(rst1), .i_req_valid(valid1), .o_req_ready(ready1),
        .i_req_state(state1), .i_req_nbounce(nb1),
        .o_sig_bouncy(pin1), .o_state(ostate1), .o_done(done1));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    // x^16 + x^14 + x^13 + x^11 + 1, MSB-first shift
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Model: on acceptance, the full per-cycle output trace is generated up front.
    typedef struct packed {
        logic level;
        logic ready;
        logic done;
        logic ostate;
    } exp_t;

    exp_t        m_cur;
    exp_t        m_q[$];
    logic [15:0] m_lfsr;
    bit          m_on = 1'b0;

    task automatic model_accept(input logic tgt, input logic [3:0] nb, input logic [15:0] v0);
        logic        lvl, old;
        int          tog, len;
        logic [15:0] l;
        old = m_cur.ostate;
        l   = v0;
        if (tgt != old) begin
            lvl = tgt;
            tog = 2 * int'(nb);
            while (1) begin
                len = int'(l[3:0]) + 1;
                for (int j = 0; j < len; j++) begin
                    l = lfsr_step(l);
                    m_q.push_back('{level: lvl, ready: 1'b0, done: 1'b0, ostate: old});
                end
                if (tog == 0) break;
                lvl = ~lvl;
                tog--;
            end
        end
        for (int j = 0; j < 64; j++)
            m_q.push_back('{level: tgt, ready: 1'b0, done: 1'b0, ostate: old});
        m_q.push_back('{level: tgt, ready: 1'b1, done: 1'b1, ostate: tgt});
    endtask

    initial begin
        m_cur  = '{level: 1'b0, ready: 1'b1, done: 1'b0, ostate: 1'b0};
        m_lfsr = SEED;
        forever begin
            @(posedge clk);
            if (rst0) begin
                m_q.delete();
                m_cur  = '{level: 1'b0, ready: 1'b1, done: 1'b0, ostate: 1'b0};
                m_lfsr = SEED;
                m_on   = 1'b1;
            end else if (m_on) begin
                if (m_cur.ready && i_req_valid)
                    model_accept(i_req_state, i_req_nbounce, m_lfsr);
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                end else begin
                    m_cur.ready = 1'b1;
                    m_cur.done  = 1'b0;
                end
                m_lfsr = lfsr_step(m_lfsr);
            end
        end
    end

    // Per-cycle comparison of dut0 against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                chk("cyc_pin",   int'(o_sig_bouncy), int'(m_cur.level));
                chk("cyc_ready", int'(o_req_ready),  int'(m_cur.ready));
                chk("cyc_done",  int'(o_done),       int'(m_cur.done));
                chk("cyc_state", int'(o_state),      int'(m_cur.ostate));
            end
        end
    end

    // Three-sample debouncers fed by the DUT pin and by the model's expected pin.
    bit   deb_en = 1'b0;
    logic deb_dut, deb_mod;
    int   cnt_dut, cnt_mod, tr_dut, tr_mod;
    initial begin
        forever begin
            @(negedge clk);
            if (deb_en) begin
                if (o_sig_bouncy != deb_dut) begin
                    cnt_dut++;
                    if (cnt_dut == 3) begin deb_dut = o_sig_bouncy; cnt_dut = 0; tr_dut++; end
                end else cnt_dut = 0;
                if (m_cur.level != deb_mod) begin
                    cnt_mod++;
                    if (cnt_mod == 3) begin deb_mod = m_cur.level; cnt_mod = 0; tr_mod++; end
                end else cnt_mod = 0;
            end
        end
    end

    task automatic run_req(input logic tgt, input logic [3:0] nb, output int lat, output int edges,
                           output int first, output int minseg, output int maxseg);
        logic prev;
        int   last;
        bit   got;
        @(negedge clk);
        i_req_valid = 1'b1; i_req_state = tgt; i_req_nbounce = nb;
        prev = o_sig_bouncy;
        lat = 0; edges = 0; first = 0; last = 0; minseg = 999; maxseg = 0; got = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (k == 1) i_req_valid = 1'b0;
            if (o_sig_bouncy !== prev) begin
                if (edges > 0) begin
                    if (k - last < minseg) minseg = k - last;
                    if (k - last > maxseg) maxseg = k - last;
                end else first = k;
                edges++; last = k; prev = o_sig_bouncy;
            end
            if (o_done) begin lat = k; got = 1'b1; break; end
        end
        chk("req_done_seen", int'(got), 1);
        if (got && edges > 0) begin
            if (lat - last - 64 < minseg) minseg = lat - last - 64;
            if (lat - last - 64 > maxseg) maxseg = lat - last - 64;
        end
    endtask

    task automatic wait_done(input string nm);
        bit got = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (o_done) begin got = 1'b1; break; end
        end
        chk(nm, int'(got), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, edges, first, mn, mx, bad, ndone;
        bit got;

        chk("model_lfsr_step1", int'(lfsr_step(SEED)), 16'h59C3);
        chk("model_lfsr_step2", int'(lfsr_step(lfsr_step(SEED))), 16'hB387);

        repeat (3) @(negedge clk);
        chk("rst_ready", int'(o_req_ready), 1);
        chk("rst_pin",   int'(o_sig_bouncy), 0);
        chk("rst_state", int'(o_state), 0);
        chk("rst_done",  int'(o_done), 0);
        rst0 = 1'b0;

        // Scenario 1: ON, no bounces
        run_req(1'b1, 4'd0, lat, edges, first, mn, mx);
        chk("s1_edges", edges, 1);
        chk("s1_first_edge_t1", first, 1);
        chk_rng("s1_done_latency", lat, 66, 81);
        chk("s1_state_on", int'(o_state), 1);

        // Scenario 3: ON while already ON
        run_req(1'b1, 4'd7, lat, edges, first, mn, mx);
        chk("s3_edges", edges, 0);
        chk("s3_done_latency", lat, 65);

        // Scenario 2: back to OFF, then ON with 3 bounces
        run_req(1'b0, 4'd0, lat, edges, first, mn, mx);
        chk("s2_pre_state_off", int'(o_state), 0);
        run_req(1'b1, 4'd3, lat, edges, first, mn, mx);
        chk("s2_edges", edges, 7);
        chk("s2_final_pin", int'(o_sig_bouncy), 1);
        chk_rng("s2_seg_min", mn, 1, 16);
        chk_rng("s2_seg_max", mx, 1, 16);
        chk("s2_state_on", int'(o_state), 1);

        // Scenario 4: request held while busy is accepted on the done cycle
        @(negedge clk);
        i_req_valid = 1'b1; i_req_state = 1'b0; i_req_nbounce = 4'd2;
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("s4_first_edge", int'(o_sig_bouncy), 0);
        @(negedge clk);
        i_req_valid = 1'b1; i_req_state = 1'b1; i_req_nbounce = 4'd0;
        bad = 0; got = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (o_done) begin got = 1'b1; break; end
            if (o_req_ready) bad++;
            @(negedge clk);
        end
        chk("s4_ready_low_busy", bad, 0);
        chk("s4_done_seen", int'(got), 1);
        chk("s4_ready_on_done", int'(o_req_ready), 1);
        chk("s4_state_off", int'(o_state), 0);
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("s4_held_accepted", int'(o_req_ready), 0);
        chk("s4_held_edge", int'(o_sig_bouncy), 1);
        wait_done("s4_held_done");
        chk("s4_held_state_on", int'(o_state), 1);

        // Reset in the middle of SETTLE
        @(negedge clk);
        i_req_valid = 1'b1; i_req_state = 1'b1; i_req_nbounce = 4'd0;
        @(negedge clk);
        i_req_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        chk("abort_ready", int'(o_req_ready), 1);
        chk("abort_state", int'(o_state), 0);
        chk("abort_pin", int'(o_sig_bouncy), 0);
        ndone = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_done) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // Scenario 6: heavy bounce through a three-sample debouncer
        deb_dut = o_sig_bouncy; deb_mod = o_sig_bouncy;
        cnt_dut = 0; cnt_mod = 0; tr_dut = 0; tr_mod = 0;
        deb_en = 1'b1;
        run_req(1'b1, 4'd15, lat, edges, first, mn, mx);
        deb_en = 1'b0;
        chk("s6_edges", edges, 31);
        chk_rng("s6_seg_max", mx, 1, 16);
        chk("s6_deb_final", int'(deb_dut), 1);
        chk("s6_deb_transitions", tr_dut, tr_mod);
        chk("s6_state_on", int'(o_state), 1);

        // Scenario 5: pull-up instance, reset during BOUNCE
        chk("s5_rst_pin", int'(pin1), 1);
        chk("s5_rst_ready", int'(ready1), 1);
        rst1 = 1'b0;
        @(negedge clk);
        valid1 = 1'b1; state1 = 1'b1; nb1 = 4'd5;
        @(negedge clk);
        valid1 = 1'b0;
        chk("s5_first_edge_low", int'(pin1), 0);
        chk("s5_busy", int'(ready1), 0);
        repeat (2) @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        chk("s5_abort_pin", int'(pin1), 1);
        chk("s5_abort_state", int'(ostate1), 0);
        chk("s5_abort_ready", int'(ready1), 1);
        ndone = 0;
        repeat (150) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        chk("s5_no_done", ndone, 0);
        chk("s5_pin_idle_high", int'(pin1), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
